// File: rtl/btn_conditioner.sv
// N-channel push-button conditioner: polarity fix, synchroniser, debounce, press/release pulses
// and per-channel auto-repeat, all in the game clock domain.
module btn_conditioner #(
    parameter int               N_BTN           = 4,
    parameter bit               ACTIVE_LOW      = 1'b1,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 250000,
    parameter logic [N_BTN-1:0] REPEAT_EN       = {N_BTN{1'b1}},
    parameter int               REPEAT_DELAY    = 25000000,
    parameter int               REPEAT_PERIOD   = 5000000
) (
    input  logic             game_clk_i,
    input  logic             game_rst_i,
    input  logic [N_BTN-1:0] btn_i,
    input  logic             enable_i,
    output logic [N_BTN-1:0] btn_level_o,
    output logic [N_BTN-1:0] btn_press_o,
    output logic [N_BTN-1:0] btn_repeat_o,
    output logic [N_BTN-1:0] btn_release_o
);

    localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DC_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RC_W   = $clog2(RC_MAX + 1);

    localparam logic [DC_W-1:0] DC_LAST   = DC_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DC_W-1:0] DC_ONE    = DC_W'(1);
    localparam logic [RC_W-1:0] RC_DELAY  = RC_W'(REPEAT_DELAY);
    localparam logic [RC_W-1:0] RC_PERIOD = RC_W'(REPEAT_PERIOD);
    localparam logic [RC_W-1:0] RC_ONE    = RC_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    logic [N_BTN-1:0] raw_s;

    assign raw_s = ACTIVE_LOW ? ~btn_i : btn_i;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        localparam bit REP_EN = REPEAT_EN[i];

        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync_s;
        logic                   level_q, level_d;
        logic [DC_W-1:0]        dc_q, dc_d;
        logic                   rise_s, fall_s, fire_s;
        rep_state_t             state_q, state_d;
        logic [RC_W-1:0]        rc_q, rc_d;
        logic                   press_q, press_d;
        logic                   release_q, release_d;
        logic                   repeat_q, repeat_d;

        // Synchroniser chain; the raw pin only ever reaches the first flop.
        always_ff @(posedge game_clk_i or posedge game_rst_i) begin
            if (game_rst_i) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw_s[i]};
            end
        end

        assign sync_s = sync_q[SYNC_STAGES-1];

        // Debounce: a level change is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
        always_comb begin
            level_d = level_q;
            dc_d    = '0;
            rise_s  = 1'b0;
            fall_s  = 1'b0;
            if (sync_s != level_q) begin
                if (dc_q == DC_LAST) begin
                    level_d = sync_s;
                    rise_s  = sync_s;
                    fall_s  = ~sync_s;
                end else begin
                    dc_d = dc_q + DC_ONE;
                end
            end else begin
                dc_d = '0;
            end
        end

        // Repeat scheduler; a release always wins over a coincident expiry.
        always_comb begin
            state_d = state_q;
            rc_d    = rc_q;
            fire_s  = 1'b0;
            if (fall_s) begin
                state_d = ST_IDLE;
                rc_d    = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rise_s && REP_EN) begin
                            state_d = ST_WAIT;
                            rc_d    = RC_ONE;
                        end else begin
                            rc_d = '0;
                        end
                    end
                    ST_WAIT: begin
                        if (rc_q == RC_DELAY) begin
                            fire_s  = 1'b1;
                            state_d = ST_REPEAT;
                            rc_d    = RC_ONE;
                        end else begin
                            rc_d = rc_q + RC_ONE;
                        end
                    end
                    ST_REPEAT: begin
                        if (rc_q == RC_PERIOD) begin
                            fire_s = 1'b1;
                            rc_d   = RC_ONE;
                        end else begin
                            rc_d = rc_q + RC_ONE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        rc_d    = '0;
                    end
                endcase
            end
        end

        assign press_d   = rise_s & enable_i;
        assign release_d = fall_s & enable_i;
        assign repeat_d  = fire_s & enable_i;

        // Channel state and registered pulse outputs.
        always_ff @(posedge game_clk_i or posedge game_rst_i) begin
            if (game_rst_i) begin
                level_q   <= 1'b0;
                dc_q      <= '0;
                state_q   <= ST_IDLE;
                rc_q      <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                level_q   <= level_d;
                dc_q      <= dc_d;
                state_q   <= state_d;
                rc_q      <= rc_d;
                press_q   <= press_d;
                release_q <= release_d;
                repeat_q  <= repeat_d;
            end
        end

        assign btn_level_o[i]   = level_q;
        assign btn_press_o[i]   = press_q;
        assign btn_release_o[i] = release_q;
        assign btn_repeat_o[i]  = repeat_q;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: debounce latency, glitch filtering, repeat timing,
// release/repeat collision, enable gating and asynchronous reset.
module tb_btn_conditioner;

    logic       clk;
    logic       rst;
    logic [3:0] btn;
    logic       en;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] rep;
    logic [3:0] rel;

    int n_cmp = 0;
    int n_err = 0;
    int press_cnt [4];
    int rel_cnt   [4];
    int rep_cnt   [4];
    int nz_cnt;

    btn_conditioner #(
        .N_BTN           (4),
        .ACTIVE_LOW      (1'b1),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8),
        .REPEAT_EN       (4'b0101),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (5)
    ) dut (
        .game_clk_i    (clk),
        .game_rst_i    (rst),
        .btn_i         (btn),
        .enable_i      (en),
        .btn_level_o   (level),
        .btn_press_o   (press),
        .btn_repeat_o  (rep),
        .btn_release_o (rel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int c = 0; c < 4; c++) begin
            press_cnt[c] = 0;
            rel_cnt[c]   = 0;
            rep_cnt[c]   = 0;
        end
        nz_cnt = 0;
    endtask

    task automatic watch(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            for (int c = 0; c < 4; c++) begin
                press_cnt[c] += int'(press[c]);
                rel_cnt[c]   += int'(rel[c]);
                rep_cnt[c]   += int'(rep[c]);
            end
            if ({level, press, rep, rel} != 16'h0000) nz_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1;
        btn = 4'hF;
        en  = 1'b1;
        clr();
        #12;
        chk4("rst_level", level, 4'h0);
        chk4("rst_press", press, 4'h0);
        chk4("rst_repeat", rep, 4'h0);
        chk4("rst_release", rel, 4'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(5);
        chk4("idle_level", level, 4'h0);

        // Clean press on ch0: level after 10 cycles, repeats at +20, +25, +30...
        btn[0] = 1'b0;
        tick(9);
        chk4("t1_level_early", level, 4'h0);
        tick(1);
        chk4("t1_level", level, 4'h1);
        chk4("t1_press", press, 4'h1);
        clr();
        watch(19);
        chki("t1_no_early_repeat", rep_cnt[0], 0);
        chki("t1_single_press", press_cnt[0], 0);
        tick(1);
        chk4("t1_repeat20", rep, 4'h1);
        clr();
        watch(4);
        chki("t1_gap", rep_cnt[0], 0);
        tick(1);
        chk4("t1_repeat25", rep, 4'h1);
        clr();
        watch(60);
        chki("t1_repeat_count", rep_cnt[0], 12);
        chki("t1_hold_press", press_cnt[0], 0);
        chki("t1_hold_release", rel_cnt[0], 0);

        // Release timed so the level drops on the cycle a repeat is due.
        btn[0] = 1'b1;
        tick(5);
        chk4("t5_repeat90", rep, 4'h1);
        tick(4);
        chk4("t5_level_held", level, 4'h1);
        chk4("t5_no_rel_early", rel, 4'h0);
        tick(1);
        chk4("t5_release", rel, 4'h1);
        chk4("t5_repeat_lost", rep, 4'h0);
        chk4("t5_level_drop", level, 4'h0);
        clr();
        watch(15);
        chki("t5_single_release", rel_cnt[0], 0);
        chki("t5_no_repeat_after", rep_cnt[0], 0);

        // Bounce on ch1, then a steady press; ch1 has repeat disabled.
        clr();
        for (int k = 0; k < 10; k++) begin
            btn[1] = k[0];
            watch(3);
        end
        btn[1] = 1'b0;
        watch(20);
        chki("t2_one_press", press_cnt[1], 1);
        chki("t2_no_release", rel_cnt[1], 0);
        chk4("t2_level", level, 4'h2);
        clr();
        watch(40);
        chki("t2_no_repeat", rep_cnt[1], 0);
        chki("t2_no_more_press", press_cnt[1], 0);
        btn[1] = 1'b1;
        tick(20);
        chk4("t2_released", level, 4'h0);

        // Glitch of 7 cycles on ch2 is filtered; 12 cycles is accepted.
        clr();
        btn[2] = 1'b0;
        watch(7);
        btn[2] = 1'b1;
        watch(20);
        chki("t3_glitch_quiet", nz_cnt, 0);
        btn[2] = 1'b0;
        tick(10);
        chk4("t3_press", press, 4'h4);
        tick(2);
        btn[2] = 1'b1;
        tick(10);
        chk4("t3_release", rel, 4'h4);
        chk4("t3_level", level, 4'h0);
        clr();
        watch(20);
        chki("t3_no_repeat", rep_cnt[2], 0);
        chki("t3_no_press", press_cnt[2], 0);

        // All channels at once; only ch0/ch2 repeat.
        btn = 4'h0;
        tick(9);
        chk4("t4_press_early", press, 4'h0);
        tick(1);
        chk4("t4_press_all", press, 4'hF);
        chk4("t4_level_all", level, 4'hF);
        clr();
        watch(19);
        chki("t4_no_early_rep0", rep_cnt[0], 0);
        chki("t4_no_early_rep2", rep_cnt[2], 0);
        tick(1);
        chk4("t4_repeat20", rep, 4'b0101);
        tick(5);
        chk4("t4_repeat25", rep, 4'b0101);

        // Asynchronous reset while repeating; buttons still held afterwards.
        #3;
        rst = 1'b1;
        #1;
        chk4("t6_rst_level", level, 4'h0);
        chk4("t6_rst_press", press, 4'h0);
        chk4("t6_rst_repeat", rep, 4'h0);
        chk4("t6_rst_release", rel, 4'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(9);
        chk4("t6_level_early", level, 4'h0);
        tick(1);
        chk4("t6_fresh_press", press, 4'hF);
        btn = 4'hF;
        tick(15);
        chk4("t6_all_released", level, 4'h0);

        // Pulses suppressed while disabled; repeat schedule keeps running.
        en = 1'b0;
        btn[0] = 1'b0;
        clr();
        watch(10);
        chk4("t7_level", level, 4'h1);
        chki("t7_no_press", press_cnt[0], 0);
        clr();
        watch(22);
        chki("t7_no_repeat", rep_cnt[0], 0);
        en = 1'b1;
        clr();
        watch(2);
        chki("t7_no_queued_press", press_cnt[0], 0);
        chki("t7_no_queued_repeat", rep_cnt[0], 0);
        tick(1);
        chk4("t7_repeat25", rep, 4'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
